// File: rtl/su_distributor_pkg.sv
// su_pkg: definitions shared by the spatial-unrolling blocks (the su_distributor
// fan-out and the su_adder_v1 reduction tree).
//   MODE_*  : 2-bit operand-distribution mode encodings
//   state_t : distributor FSM state (ST_FILL collects lanes, ST_HOLD presents them)
package su_pkg;

  localparam logic [1:0] MODE_SCATTER = 2'b00;
  localparam logic [1:0] MODE_DIRECT  = 2'b01;
  localparam logic [1:0] MODE_BCAST   = 2'b10;
  localparam logic [1:0] MODE_CLEAR   = 2'b11;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/su_distributor_if.sv
// su_distributor_if: bundles the operand input handshake and the lane-vector
// output handshake of su_distributor.
//   in_valid/in_ready/in_data/in_mode/in_dst : one operand word per handshake
//   out_valid/out_ready/out_data             : full lane vector to the PE array
//   out_lane_valid                           : per-lane loaded flags
// master = upstream/PE-array side, slave = distributor side.
interface su_distributor_if #(
  parameter int DATA_BITWIDTH = 16,
  parameter int NUM_PE        = 8
);
  localparam int LANE_BITS = $clog2(NUM_PE);

  logic                            in_valid;
  logic                            in_ready;
  logic [DATA_BITWIDTH-1:0]        in_data;
  logic [1:0]                      in_mode;
  logic [LANE_BITS-1:0]            in_dst;
  logic                            out_valid;
  logic                            out_ready;
  logic [NUM_PE*DATA_BITWIDTH-1:0] out_data;
  logic [NUM_PE-1:0]               out_lane_valid;

  modport master (
    output in_valid, in_data, in_mode, in_dst, out_ready,
    input  in_ready, out_valid, out_data, out_lane_valid
  );

  modport slave (
    input  in_valid, in_data, in_mode, in_dst, out_ready,
    output in_ready, out_valid, out_data, out_lane_valid
  );
endinterface

// File: rtl/su_dist_lane.sv
// su_dist_lane: one operand lane register with a loaded flag.
//   clk, rst : clock, synchronous active-high reset (zeroes data and flag)
//   we, load : write load into the lane and mark it valid
//   clr      : zero the data and drop the flag
//   inv      : drop the flag only; data is kept for inspection after release
//   data     : lane contents
//   valid    : lane holds a word for the current vector
module su_dist_lane #(
  parameter int DATA_BITWIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic                     clr,
  input  logic                     inv,
  input  logic [DATA_BITWIDTH-1:0] load,
  output logic [DATA_BITWIDTH-1:0] data,
  output logic                     valid
);

  always_ff @(posedge clk) begin
    if (rst || clr) data <= '0;
    else if (we)    data <= load;
  end

  always_ff @(posedge clk) begin
    if (rst || clr || inv) valid <= 1'b0;
    else if (we)           valid <= 1'b1;
  end

endmodule

// File: rtl/su_distributor.sv
// su_distributor: stages one operand word per handshake into NUM_PE lane
// registers (scatter / direct / broadcast / clear) and presents the full lane
// vector to the PE array once every lane is loaded, holding it until accepted.
//   clk, rst : clock, synchronous active-high reset
//   bus      : su_distributor_if slave modport (input word handshake, output
//              vector handshake, per-lane loaded flags)
module su_distributor
  import su_pkg::*;
#(
  parameter int DATA_BITWIDTH = 16,
  parameter int NUM_PE        = 8
) (
  input logic        clk,
  input logic        rst,
  su_distributor_if.slave bus
);

  localparam int LANE_BITS = $clog2(NUM_PE);

  state_t               state;
  state_t               state_next;
  logic [LANE_BITS-1:0] scatter_ptr;
  logic                 in_ready;
  logic                 out_valid;
  logic                 accept;
  logic                 do_clear;
  logic                 release_vec;
  logic [NUM_PE-1:0]    lane_we;
  logic [NUM_PE-1:0]    lane_valid;
  logic [NUM_PE-1:0]    valid_next;

  // Write decode for the accepted word, and the flag vector it will produce.
  always_comb begin
    accept      = bus.in_valid && in_ready;
    do_clear    = accept && (bus.in_mode == MODE_CLEAR);
    release_vec = (state == ST_HOLD) && bus.out_ready;
    lane_we     = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      if (accept) begin
        case (bus.in_mode)
          MODE_SCATTER: lane_we[i] = (scatter_ptr == LANE_BITS'(i));
          MODE_DIRECT:  lane_we[i] = (bus.in_dst == LANE_BITS'(i));
          MODE_BCAST:   lane_we[i] = 1'b1;
          default:      lane_we[i] = 1'b0;
        endcase
      end
    end
    valid_next = do_clear ? '0 : (lane_valid | lane_we);
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_FILL;
    else     state <= state_next;
  end

  // FSM next state: CLEAR yields an all-zero flag vector, so it never fills.
  always_comb begin
    state_next = state;
    case (state)
      ST_FILL: if (accept && (&valid_next)) state_next = ST_HOLD;
      ST_HOLD: if (bus.out_ready)           state_next = ST_FILL;
      default:                              state_next = ST_FILL;
    endcase
  end

  // FSM outputs: registered-state only, so no same-cycle refill after release.
  always_comb begin
    in_ready  = (state == ST_FILL) && !rst;
    out_valid = (state == ST_HOLD);
  end

  // Scatter pointer wraps naturally at NUM_PE (power of two).
  always_ff @(posedge clk) begin
    if (rst || release_vec) begin
      scatter_ptr <= '0;
    end else if (accept) begin
      case (bus.in_mode)
        MODE_SCATTER: scatter_ptr <= scatter_ptr + LANE_BITS'(1);
        MODE_DIRECT:  scatter_ptr <= scatter_ptr;
        default:      scatter_ptr <= '0;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_PE; g++) begin : g_lane
    su_dist_lane #(
      .DATA_BITWIDTH(DATA_BITWIDTH)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .we    (lane_we[g]),
      .clr   (do_clear),
      .inv   (release_vec),
      .load  (bus.in_data),
      .data  (bus.out_data[g*DATA_BITWIDTH +: DATA_BITWIDTH]),
      .valid (lane_valid[g])
    );
  end

  assign bus.in_ready       = in_ready;
  assign bus.out_valid      = out_valid;
  assign bus.out_lane_valid = lane_valid;

endmodule

// File: doc/su_distributor.md
Name: su_distributor

Overview:
- Spatial-unrolling operand distributor: the fan-out counterpart of the su_adder_v1 reduction tree.
- Accepts one operand word per valid/ready handshake and stages it into NUM_PE lane registers, by one of four 2-bit modes.
- Modes: sequential scatter, directed write, broadcast, clear.
- When every lane holds valid data, presents the full vector to the PE array and holds it until the array accepts it.

Parameters:
DATA_BITWIDTH, 16, width of one operand word / lane
NUM_PE, 8, number of output lanes; power of two, >=2
LANE_BITS, $clog2(NUM_PE), derived localparam, lane index width

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
in_valid  input  1  upstream word valid
in_ready  output  1  distributor can accept a word this cycle
in_data  input  DATA_BITWIDTH  operand word
in_mode  input  2  00 scatter, 01 direct, 10 broadcast, 11 clear
in_dst  input  LANE_BITS  target lane for direct mode; ignored otherwise
out_valid  output  1  full lane vector is presented
out_ready  input  1  PE array accepts the vector
out_data  output  NUM_PE*DATA_BITWIDTH  lane i at bits [i*DATA_BITWIDTH +: DATA_BITWIDTH]
out_lane_valid  output  NUM_PE  per-lane loaded flags (debug/partial use)

Behaviour:
- Reset: one clk edge with rst=1.
  - State FILL; all lane data 0; out_lane_valid 0; scatter_ptr 0; out_valid 0.
  - in_ready is 0 while rst=1.
- States: FILL, HOLD. in_ready = (state==FILL) && !rst. It does not depend on in_valid.
- out_valid = (state==HOLD), from the state register only.
- Accept = in_valid && in_ready. All updates happen on the accepting edge:
  - 00 SCATTER: lane[scatter_ptr]<=in_data, valid[scatter_ptr]<=1. scatter_ptr<=scatter_ptr+1, wrapping NUM_PE-1 -> 0.
  - 01 DIRECT: lane[in_dst]<=in_data, valid[in_dst]<=1. scatter_ptr unchanged.
  - 10 BROADCAST: all lanes<=in_data, all valid<=1. scatter_ptr<=0.
  - 11 CLEAR: all lanes<=0, all valid<=0. scatter_ptr<=0. in_data is ignored.
- Overwrite: a write to an already-valid lane replaces its data; its valid flag stays 1.
- FILL->HOLD: on the accepting edge whose resulting valid vector is all-ones.
  - out_valid rises in the cycle immediately after that handshake (latency 1).
  - CLEAR never causes HOLD.
- HOLD:
  - in_ready=0. Lane data and out_lane_valid stay frozen.
  - On the edge where out_ready=1: valid<=0, scatter_ptr<=0, state<=FILL. Lane data is retained, not zeroed.
  - in_ready returns to 1 the cycle after the release. There is no same-cycle refill.
- out_ready in FILL is ignored.
- rst mid-operation, in either state, returns to the reset values on that edge. A pending vector is discarded.
- Unused mode encodings: none; all four are defined.
- Arithmetic: pointer only; modulo NUM_PE by natural wrap of a LANE_BITS-wide register.

Decomposition:
- Shared package su_pkg holds:
  - mode localparams MODE_SCATTER=2'b00, MODE_DIRECT=2'b01, MODE_BCAST=2'b10, MODE_CLEAR=2'b11;
  - state encodings ST_FILL, ST_HOLD.
- su_adder_v1 control also imports su_pkg.
- One sub-module: su_dist_lane, a single-lane register with write-enable, load value, clear, and valid flag.
  - Instantiated NUM_PE times by generate.
  - The top holds the FSM and scatter_ptr.

Test Plan (bench instance NUM_PE=4, DATA_BITWIDTH=16):
- Reset then idle -> in_ready=1, out_valid=0, out_data=0, out_lane_valid=4'b0000.
- Scatter 0x0011,0x0022,0x0033,0x0044 on back-to-back cycles with out_ready=0:
  - out_valid=1 exactly one cycle after the 4th accept;
  - out_data={0x0044,0x0033,0x0022,0x0011};
  - in_ready=0 while held.
  - Pulse out_ready: the next cycle shows out_valid=0, in_ready=1, lane_valid=0000.
- Broadcast 0xBEEF -> next cycle out_valid=1 and all four lanes=0xBEEF.
- Direct dst=2 with 0x00AA, then direct dst=2 with 0x00BB, then scatter 0x1,0x2,0x3:
  - lanes {3,2,1,0}={0x3,0x00BB,0x2,0x1}... no, the scatter order is ptr 0,1,2. So lanes become lane0=0x1, lane1=0x2, lane2=0x3 (overwriting 0x00BB), lane3 invalid.
  - out_valid stays 0 and lane_valid=0111.
  - A 4th scatter 0x4 completes: out_valid=1, lane3=0x4.
- Scatter 0x5,0x6, then CLEAR, then scatter 0x7 -> lane_valid=0001, lane0=0x7, lane1=0. CLEAR reset the pointer.
- Fill via broadcast; while HOLD, assert rst with out_ready=0 -> next cycle out_valid=0, all lanes 0, in_ready=1 after rst deasserts.
